// File: rtl/mem_if_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_if_pkg
//  Description : Shared definitions for the request/response memory interface:
//                FSM state encoding, default widths and a byte-merge helper.
//                The helper works at the default width and is meant for
//                reference models on the initiator side.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_if_pkg;

  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 16;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_t;

  // Byte i of the result comes from wdata when wmask[i] is set, else from old.
  function automatic logic [DATA_W_DEF-1:0] merge_bytes(
    input logic [DATA_W_DEF-1:0]   old,
    input logic [DATA_W_DEF-1:0]   wdata,
    input logic [DATA_W_DEF/8-1:0] wmask
  );
    logic [DATA_W_DEF-1:0] res;
    res = old;
    for (int i = 0; i < DATA_W_DEF/8; i++) begin
      if (wmask[i]) res[8*i +: 8] = wdata[8*i +: 8];
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/byte_merge.sv
`default_nettype none
// ============================================================================
//  Module      : byte_merge
//  Description : Combinational masked byte merge.
//                o_merged byte i = i_wmask[i] ? i_wdata byte i : i_old byte i
//  Ports       : i_old    [DATA_W]   current word
//                i_wdata  [DATA_W]   new data
//                i_wmask  [DATA_W/8] byte enables
//                o_merged [DATA_W]   merged word
//  Revision    : 1.0 - initial release
// ============================================================================
module byte_merge #(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0]   i_old,
  input  logic [DATA_W-1:0]   i_wdata,
  input  logic [DATA_W/8-1:0] i_wmask,
  output logic [DATA_W-1:0]   o_merged
);

  for (genvar i = 0; i < DATA_W/8; i++) begin : g_byte
    assign o_merged[8*i +: 8] = i_wmask[i] ? i_wdata[8*i +: 8] : i_old[8*i +: 8];
  end

endmodule
`default_nettype wire

// File: rtl/ram_responder.sv
`default_nettype none
// ============================================================================
//  Module      : ram_responder
//  Description : Memory-side target. Accepts one read/write request at a time,
//                performs it on an internal register-file RAM and returns one
//                registered response with valid/ready backpressure. The last
//                successfully written word is exposed on mem_store.
//  Ports       : clk, rst                   clock, sync active-high reset
//                req_valid/req_ready        request handshake
//                req_we/addr/wdata/wmask    request fields
//                rsp_valid/rsp_ready        response handshake
//                rsp_rdata/rsp_err          response payload
//                mem_store                  last written (merged) word
//  Revision    : 1.0 - initial release
// ============================================================================
module ram_responder
  import mem_if_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 12
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_wmask,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic [DATA_W-1:0]   mem_store
);

  // Depth widened by one bit so DEPTH == 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0] c_depth = DEPTH[ADDR_W:0];

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   ram_q [DEPTH];
  logic [DATA_W-1:0]   ram_d [DEPTH];
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0]   mem_store_q, mem_store_d;

  logic                in_range;
  logic [DATA_W-1:0]   old_word;
  logic [DATA_W-1:0]   merged_word;

  assign in_range = ({1'b0, req_addr} < c_depth);
  // Guarded so an out-of-range address never indexes past the array.
  assign old_word = in_range ? ram_q[req_addr] : '0;

  byte_merge #(
    .DATA_W (DATA_W)
  ) u_byte_merge (
    .i_old    (old_word),
    .i_wdata  (req_wdata),
    .i_wmask  (req_wmask),
    .o_merged (merged_word)
  );

  always_comb begin
    state_d     = state_q;
    ram_d       = ram_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    mem_store_d = mem_store_q;
    case (state_q)
      IDLE: begin
        // req_ready is 1 in IDLE, so accept reduces to req_valid.
        if (req_valid) begin
          state_d = RESP;
          if (in_range) begin
            rsp_err_d = 1'b0;
            if (req_we) begin
              ram_d[req_addr] = merged_word;
              mem_store_d     = merged_word;
              rsp_rdata_d     = merged_word;
            end else begin
              rsp_rdata_d = old_word;
            end
          end else begin
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      mem_store_q <= '0;
      for (int i = 0; i < DEPTH; i++) ram_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      mem_store_q <= mem_store_d;
      ram_q       <= ram_d;
    end
  end

  // All outputs come straight from flops: no combinational input-to-output path.
  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign mem_store = mem_store_q;

endmodule
`default_nettype wire
